// File: rtl/mdu_iter_if.sv
// Handshake and result bundle between the decode stage and the multiply/divide unit.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             pc_ena;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mul_out;

    modport master (
        output start, op, a, b,
        input  pc_ena, busy, done, hi, lo, mul_out
    );

    modport slave (
        input  start, op, a, b,
        output pc_ena, busy, done, hi, lo, mul_out
    );
endinterface

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit with HI/LO registers; stalls the PC until the result is committed.
// Multiplies take MUL_LATENCY cycles, divides run a restoring divider producing one quotient bit per cycle.
module mdu_iter #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic      clk,
    input  logic      rst,
    mdu_iter_if.slave bus
);
    localparam int MAX_CNT = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LATENCY);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic               signed_q;
    logic [WIDTH-1:0]   opA_q;
    logic [WIDTH-1:0]   opB_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   mulOut_q;
    logic               busy_q;
    logic               done_q;

    logic               isMul;
    logic               isDiv;
    logic               accept;
    logic [WIDTH-1:0]   absA_d;
    logic [WIDTH-1:0]   absB_d;
    logic [2*WIDTH-1:0] extA_d;
    logic [2*WIDTH-1:0] extB_d;
    logic [2*WIDTH-1:0] product_d;
    logic [WIDTH:0]     shifted_d;
    logic [WIDTH:0]     diff_d;
    logic [WIDTH-1:0]   remNext_d;
    logic [WIDTH-1:0]   quoNext_d;
    logic               negQ_d;
    logic               negR_d;
    logic               divZero_d;
    logic [WIDTH-1:0]   divLo_d;
    logic [WIDTH-1:0]   divHi_d;

    assign isMul  = (bus.op == 3'b001) || (bus.op == 3'b010);
    assign isDiv  = (bus.op == 3'b011) || (bus.op == 3'b100);
    assign accept = (state_q == IDLE) && bus.start;

    assign bus.pc_ena  = rst || !((accept && (isMul || isDiv)) || (state_q == MUL) || (state_q == DIV));
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.mul_out = mulOut_q;

    // The divider works on magnitudes; signs are reapplied when the result is committed.
    always_comb begin
        absA_d = bus.a;
        absB_d = bus.b;
        if (bus.op == 3'b011) begin
            if (bus.a[WIDTH-1]) absA_d = -bus.a;
            if (bus.b[WIDTH-1]) absB_d = -bus.b;
        end
    end

    assign extA_d    = {{WIDTH{signed_q & opA_q[WIDTH-1]}}, opA_q};
    assign extB_d    = {{WIDTH{signed_q & opB_q[WIDTH-1]}}, opB_q};
    assign product_d = extA_d * extB_d;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted_d = {rem_q, quo_q[WIDTH-1]};
        diff_d    = shifted_d - {1'b0, divisor_q};
        remNext_d = diff_d[WIDTH] ? shifted_d[WIDTH-1:0] : diff_d[WIDTH-1:0];
        quoNext_d = {quo_q[WIDTH-2:0], ~diff_d[WIDTH]};
    end

    // Most-negative / -1 falls out naturally: the magnitude 2^(W-1) negates back to itself.
    always_comb begin
        negQ_d    = signed_q & (opA_q[WIDTH-1] ^ opB_q[WIDTH-1]);
        negR_d    = signed_q & opA_q[WIDTH-1];
        divZero_d = (opB_q == '0);
        divLo_d   = negQ_d ? -quoNext_d : quoNext_d;
        divHi_d   = negR_d ? -remNext_d : remNext_d;
        if (divZero_d) begin
            divLo_d = '1;
            divHi_d = opA_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            signed_q  <= 1'b0;
            opA_q     <= '0;
            opB_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mulOut_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            3'b001, 3'b010: begin
                                state_q  <= MUL;
                                busy_q   <= 1'b1;
                                cnt_q    <= CNT_ONE;
                                opA_q    <= bus.a;
                                opB_q    <= bus.b;
                                signed_q <= (bus.op == 3'b001);
                            end
                            3'b011, 3'b100: begin
                                state_q   <= DIV;
                                busy_q    <= 1'b1;
                                cnt_q     <= CNT_ONE;
                                opA_q     <= bus.a;
                                opB_q     <= bus.b;
                                signed_q  <= (bus.op == 3'b011);
                                rem_q     <= '0;
                                quo_q     <= absA_d;
                                divisor_q <= absB_d;
                            end
                            3'b101:  hi_q <= bus.a;
                            3'b110:  lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (cnt_q == MUL_LAST) begin
                        hi_q     <= product_d[2*WIDTH-1:WIDTH];
                        lo_q     <= product_d[WIDTH-1:0];
                        mulOut_q <= product_d[WIDTH-1:0];
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DIV: begin
                    rem_q <= remNext_d;
                    quo_q <= quoNext_d;
                    if (cnt_q == DIV_LAST) begin
                        hi_q    <= divHi_d;
                        lo_q    <= divLo_d;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// Randomised self-checking bench for mdu_iter against a plain-arithmetic HI/LO model.
module tb_mdu_iter;
    localparam int WIDTH       = 32;
    localparam int MUL_LATENCY = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] modelHi;
    logic [31:0] modelLo;
    logic [31:0] modelMul;

    mdu_iter_if #(.WIDTH(WIDTH)) bus ();

    mdu_iter #(.WIDTH(WIDTH), .MUL_LATENCY(MUL_LATENCY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Returns {hi, lo} as the architecture defines them, using native wide arithmetic.
    function automatic logic [63:0] modelMdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        case (op)
            3'b001: res = sa * sb;
            3'b010: res = {32'h0, a} * {32'h0, b};
            3'b011: begin
                if (b == 0) res = {a, 32'hFFFFFFFF};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'b100: begin
                if (b == 0) res = {a, 32'hFFFFFFFF};
                else res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Called right after a falling edge; returns right after a later falling edge with start dropped.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] expect64;
        int          cycles;
        int          busyOk;
        int          expStall;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        #1;
        if (op >= 3'b001 && op <= 3'b100) begin
            expect64 = modelMdu(op, a, b);
            expStall = (op <= 3'b010) ? MUL_LATENCY + 1 : WIDTH + 1;
            checkOutput("pcEnaAccept", bus.pc_ena, 0);
            checkOutput("busyAccept", bus.busy, 0);
            cycles = 1;
            busyOk = 1;
            @(negedge clk);
            bus.a = $urandom;
            bus.b = $urandom;
            while (bus.pc_ena === 1'b0 && cycles < 100) begin
                if (bus.busy !== 1'b1) busyOk = 0;
                cycles++;
                @(negedge clk);
            end
            checkOutput("stallCycles", cycles, expStall);
            checkOutput("busyWhileStalled", busyOk, 1);
            modelHi = expect64[63:32];
            modelLo = expect64[31:0];
            if (op <= 3'b010) modelMul = expect64[31:0];
            checkOutput("doneInDone", bus.done, 1);
            checkOutput("busyInDone", bus.busy, 0);
            checkOutput("hiResult", bus.hi, modelHi);
            checkOutput("loResult", bus.lo, modelLo);
            checkOutput("mulOut", bus.mul_out, modelMul);
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            checkOutput("doneAfter", bus.done, 0);
            checkOutput("noReExecute", bus.busy, 0);
            checkOutput("pcEnaAfter", bus.pc_ena, 1);
        end else begin
            checkOutput("pcEnaNoStall", bus.pc_ena, 1);
            if (op == 3'b101) modelHi = a;
            if (op == 3'b110) modelLo = a;
            @(negedge clk);
            bus.start = 1'b0;
            checkOutput("hiMove", bus.hi, modelHi);
            checkOutput("loMove", bus.lo, modelLo);
            checkOutput("busyMove", bus.busy, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        checks    = 0;
        errors    = 0;
        modelHi   = '0;
        modelLo   = '0;
        modelMul  = '0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        checkOutput("rstPcEnaForced", bus.pc_ena, 1);
        rst = 1'b0;
        #1;
        checkOutput("rstHi", bus.hi, 0);
        checkOutput("rstLo", bus.lo, 0);
        checkOutput("rstMulOut", bus.mul_out, 0);
        checkOutput("rstBusy", bus.busy, 0);
        checkOutput("rstDone", bus.done, 0);
        checkOutput("rstPcEna", bus.pc_ena, 1);
        @(negedge clk);

        $display("[TB] directed operations");
        applyStimulus(3'b001, 32'hFFFFFFFD, 32'h00000005);
        applyStimulus(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF);
        applyStimulus(3'b011, 32'hFFFFFFF9, 32'h00000002);
        applyStimulus(3'b100, 32'h00000064, 32'h00000007);
        applyStimulus(3'b100, 32'h00000064, 32'h00000000);
        applyStimulus(3'b011, 32'h80000000, 32'hFFFFFFFF);
        applyStimulus(3'b011, 32'hFFFFFFF9, 32'h00000000);
        applyStimulus(3'b101, 32'h12345678, 32'h0);
        applyStimulus(3'b110, 32'h9ABCDEF0, 32'h0);
        applyStimulus(3'b111, 32'hDEADBEEF, 32'h0);

        $display("[TB] reset during divide");
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.a     = 32'h7FFF1234;
        bus.b     = 32'h00000013;
        repeat (10) @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b0;
        #1;
        checkOutput("pcEnaInReset", bus.pc_ena, 1);
        @(negedge clk);
        rst      = 1'b0;
        modelHi  = '0;
        modelLo  = '0;
        modelMul = '0;
        #1;
        checkOutput("midRstHi", bus.hi, 0);
        checkOutput("midRstLo", bus.lo, 0);
        checkOutput("midRstBusy", bus.busy, 0);
        checkOutput("midRstPcEna", bus.pc_ena, 1);
        @(negedge clk);
        #1;
        checkOutput("midRstStaysIdle", bus.busy, 0);
        applyStimulus(3'b001, 32'h00001234, 32'hFFFF0001);

        $display("[TB] randomised operations");
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            applyStimulus(rop, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the single-cycle MIPS core.
- Successor to the fixed 32-bit MDU. Adds generic operand width, a configurable multiply latency, a bit-serial restoring divider, and defined divide-by-zero and overflow results.
- Stalls the PC through pc_ena until its result is committed.

Parameters:
WIDTH, 32, operand/HI/LO width (>=4)
MUL_LATENCY, 2, cycles spent in MUL state (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  decoded MDU instruction present this cycle
op  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none
a  in  WIDTH  rs operand (rdata1)
b  in  WIDTH  rt operand (rdata2)
pc_ena  out  1  0 = hold PC/instruction
busy  out  1  state is MUL or DIV
done  out  1  one-cycle pulse in DONE state
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
mul_out  out  WIDTH  registered low WIDTH bits of last product

Behaviour:
- Reset: state=IDLE; hi=lo=mul_out=0; busy=0; done=0; pc_ena=1. pc_ena is forced to 1 while rst=1.
- States: IDLE, MUL, DIV, DONE.
- Accept condition: start=1 while in IDLE.
- IDLE transitions:
  - op=001/010 -> MUL; op=011/100 -> DIV. a, b and signedness are latched at the accept edge.
  - op=101: hi<=a at the edge; op=110: lo<=a at the edge. No state change, no stall.
  - op=000/111 or start=0: stay in IDLE.
- pc_ena (combinational) = 0 when (IDLE & start & op in 001..100) or state in {MUL, DIV}; 1 otherwise.
- Timing: accept cycle is T0.
  - Multiply: MUL occupies T1..T(MUL_LATENCY); DONE is T(MUL_LATENCY+1).
  - Divide: DIV occupies T1..T(WIDTH), one quotient bit per cycle; DONE is T(WIDTH+1).
  - hi/lo (and mul_out for multiplies) load at the edge ending the last MUL/DIV cycle and are valid in DONE.
  - Total stall: MUL_LATENCY+1 cycles for multiply, WIDTH+1 cycles for divide.
- DONE: pc_ena=1, done=1, start ignored (the same instruction is still on the bus). Always -> IDLE next cycle.
- Multiply results:
  - Full 2*WIDTH product; hi = upper half, lo = lower half.
  - mult treats operands as two's-complement; multu as unsigned.
  - Intermediate pipeline may be registered in any way, provided the exact latency above holds.
- Divide results:
  - lo = quotient, hi = remainder.
  - Signed (div): operate on magnitudes; quotient truncates toward zero; remainder takes the dividend's sign; |remainder| < |divisor|.
  - Divisor 0 (div and divu): lo = all ones, hi = dividend (a). Same latency as a normal divide.
  - div of most-negative value by -1: lo = most-negative value, hi = 0. No exception.
- Operand inputs a/b are ignored after the accept edge.
- mthi/mtlo are only accepted in IDLE; in other states they are ignored, and the stall guarantees they do not occur there.
- Reset mid-operation: returns to IDLE and clears hi/lo at the reset edge; no partial result is ever written.
- Back-to-back: a new MDU op may be accepted in the cycle after DONE.

Test Plan:
(WIDTH=32, MUL_LATENCY=2)
1. Signed mult: mult a=FFFFFFFD (-3), b=00000005 -> pc_ena low T0..T2, done in T3; hi=FFFFFFFF, lo=FFFFFFF1, mul_out=FFFFFFF1.
2. Unsigned mult: multu a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001 after a 3-cycle stall.
3. Signed div: div a=FFFFFFF9 (-7), b=00000002 -> pc_ena low 33 cycles, done at T33; lo=FFFFFFFD, hi=FFFFFFFF. divu a=00000064, b=00000007 -> lo=0000000E, hi=00000002.
4. Edge divides:
   - divu a=00000064, b=0 -> lo=FFFFFFFF, hi=00000064.
   - div a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
5. mthi/mtlo and DONE handling:
   - mthi a=12345678 then mtlo a=9ABCDEF0 on consecutive cycles -> pc_ena stays 1; hi/lo updated at the next edge.
   - start held high through DONE -> no re-execution; IDLE next cycle.
6. Reset mid-divide: assert rst at T10 -> next cycle state IDLE, hi=lo=0, busy=0, pc_ena=1. A fresh mult then completes normally.
